// File: rtl/store_result_checker_if.sv
// store_result_checker_if
//   Bundles the processor store bus, the store-log read port and the
//   checker status outputs into one interface.
//   master : drives the store bus and log_rd_en, observes status/log
//   slave  : the checker itself
interface store_result_checker_if #(
   parameter int LOG_DEPTH = 8
);
   localparam int LW = $clog2(LOG_DEPTH) + 1;

   logic          memwrite;
   logic [31:0]   dataadr;
   logic [31:0]   writedata;
   logic          log_rd_en;
   logic          done;
   logic          pass;
   logic          fail;
   logic          timeout;
   logic [15:0]   store_count;
   logic [31:0]   fail_addr;
   logic [31:0]   fail_data;
   logic          log_valid;
   logic [31:0]   log_addr;
   logic [31:0]   log_data;
   logic [LW-1:0] log_level;
   logic          log_overflow;

   modport master (
      output memwrite, dataadr, writedata, log_rd_en,
      input  done, pass, fail, timeout, store_count, fail_addr, fail_data,
             log_valid, log_addr, log_data, log_level, log_overflow
   );

   modport slave (
      input  memwrite, dataadr, writedata, log_rd_en,
      output done, pass, fail, timeout, store_count, fail_addr, fail_data,
             log_valid, log_addr, log_data, log_level, log_overflow
   );
endinterface

// File: rtl/store_result_checker.sv
// store_result_checker
//   Watches the data-memory store bus of a single-cycle MIPS core and
//   decides PASS / FAIL / TIMEOUT in hardware. Every store seen while
//   running is counted and logged into a first-word-fall-through FIFO.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low (0 = reset)
//   bus    : slave modport; inputs memwrite/dataadr/writedata/log_rd_en,
//            outputs done/pass/fail/timeout, store_count, fail_addr/data,
//            log_valid/addr/data/level, log_overflow
module store_result_checker #(
   parameter logic [31:0] PASS_ADDR      = 32'd84,
   parameter logic [31:0] PASS_DATA      = 32'd7,
   parameter logic [31:0] ALLOW_ADDR     = 32'd80,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          LOG_DEPTH      = 8
) (
   input logic              clk,
   input logic              reset,
   store_result_checker_if.slave bus
);
   localparam int AW = $clog2(LOG_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_RUN     = 2'b00,
      S_PASS    = 2'b01,
      S_FAIL    = 2'b10,
      S_TIMEOUT = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [31:0]     fail_addr_q, fail_addr_d;
   logic [31:0]     fail_data_q, fail_data_d;
   logic            done_q, pass_q, fail_q, timeout_q;

   logic [31:0]     mem_addr [LOG_DEPTH];
   logic [31:0]     mem_data [LOG_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q, ovf_d;

   logic            store, pop, full, wr_en;

   // ---------------- checker FSM / counters ----------------
   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      cnt_d       = cnt_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      store       = (state_q == S_RUN) && bus.memwrite;

      if (state_q == S_RUN) begin
         cyc_d = cyc_q + 1'b1;
         if (store && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;

         // A terminating store beats the timeout on the same edge; a store
         // to the allowed address is not terminating and does not.
         if (store && bus.dataadr == PASS_ADDR && bus.writedata == PASS_DATA) begin
            state_d = S_PASS;
         end else if (store && bus.dataadr != ALLOW_ADDR) begin
            state_d     = S_FAIL;
            fail_addr_d = bus.dataadr;
            fail_data_d = bus.writedata;
         end else if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_TIMEOUT;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_RUN;
         cyc_q       <= '0;
         cnt_q       <= '0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         cnt_q       <= cnt_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         // Flags registered from the next state so they are flop outputs.
         done_q      <= (state_d != S_RUN);
         pass_q      <= (state_d == S_PASS);
         fail_q      <= (state_d == S_FAIL);
         timeout_q   <= (state_d == S_TIMEOUT);
      end
   end

   // ---------------- store log FIFO ----------------
   always_comb begin
      pop      = bus.log_rd_en && (level_q != '0);
      full     = (level_q == LW'(LOG_DEPTH));
      // When full, a concurrent pop frees the slot the push needs.
      wr_en    = store && (!full || pop);
      ovf_d    = ovf_q | (store && full && !pop);
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      if (wr_en && !pop)      level_d = level_q + 1'b1;
      else if (!wr_en && pop) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_addr[wr_ptr_q] <= bus.dataadr;
         mem_data[wr_ptr_q] <= bus.writedata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus.done         = done_q;
   assign bus.pass         = pass_q;
   assign bus.fail         = fail_q;
   assign bus.timeout      = timeout_q;
   assign bus.store_count  = cnt_q;
   assign bus.fail_addr    = fail_addr_q;
   assign bus.fail_data    = fail_data_q;
   assign bus.log_valid    = (level_q != '0);
   assign bus.log_addr     = mem_addr[rd_ptr_q];
   assign bus.log_data     = mem_data[rd_ptr_q];
   assign bus.log_level    = level_q;
   assign bus.log_overflow = ovf_q;
endmodule

// File: tb/tb_store_result_checker.sv
module tb_store_result_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   always #5 clk = ~clk;

   store_result_checker_if #(.LOG_DEPTH(8)) b1 ();
   store_result_checker_if #(.LOG_DEPTH(8)) b2 ();

   store_result_checker #(.TIMEOUT_CYCLES(1000), .LOG_DEPTH(8)) u_dut (
      .clk(clk), .reset(rst_n), .bus(b1));
   store_result_checker #(.TIMEOUT_CYCLES(20), .LOG_DEPTH(8)) u_dut_to (
      .clk(clk), .reset(rst2_n), .bus(b2));

   int n_chk = 0;
   int n_err = 0;

   // reference model of dut #1
   logic [63:0] exp_q[$];
   bit          m_run, m_pass, m_fail, m_ovf;
   int          m_cnt;
   logic [31:0] m_fa, m_fd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_run = 1; m_pass = 0; m_fail = 0; m_ovf = 0; m_cnt = 0; m_fa = 0; m_fd = 0;
   endtask

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input bit popping);
      if (!m_run) return;
      m_cnt++;
      if (exp_q.size() < 8 || popping) exp_q.push_back({a, d});
      else m_ovf = 1;
      if (a == 32'd84 && d == 32'd7) begin m_run = 0; m_pass = 1; end
      else if (a != 32'd80) begin m_run = 0; m_fail = 1; m_fa = a; m_fd = d; end
   endtask

   task automatic check_status(input string tag);
      chk({tag, ".done"},  b1.done,  !m_run);
      chk({tag, ".pass"},  b1.pass,  m_pass);
      chk({tag, ".fail"},  b1.fail,  m_fail);
      chk({tag, ".tmo"},   b1.timeout, 0);
      chk({tag, ".cnt"},   b1.store_count, m_cnt);
      chk({tag, ".faddr"}, b1.fail_addr, m_fa);
      chk({tag, ".fdata"}, b1.fail_data, m_fd);
      chk({tag, ".level"}, b1.log_level, exp_q.size());
      chk({tag, ".valid"}, b1.log_valid, exp_q.size() != 0);
      chk({tag, ".ovf"},   b1.log_overflow, m_ovf);
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 0;
      model_reset();
      @(negedge clk); rst_n = 1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      b1.memwrite = 1; b1.dataadr = a; b1.writedata = d;
      model_store(a, d, 0);
      @(negedge clk);
      b1.memwrite = 0;
   endtask

   // store with a concurrent pop; head is checked before the edge
   task automatic store_pop(input logic [31:0] a, input logic [31:0] d);
      logic [63:0] h;
      @(negedge clk);
      h = exp_q.pop_front();
      chk("sp.head", {b1.log_addr, b1.log_data}, h);
      b1.memwrite = 1; b1.dataadr = a; b1.writedata = d; b1.log_rd_en = 1;
      model_store(a, d, 1);
      @(negedge clk);
      b1.memwrite = 0; b1.log_rd_en = 0;
   endtask

   task automatic pop_chk(input string tag);
      logic [63:0] h;
      @(negedge clk);
      h = exp_q.pop_front();
      chk({tag, ".valid"}, b1.log_valid, 1);
      chk({tag, ".head"}, {b1.log_addr, b1.log_data}, h);
      b1.log_rd_en = 1;
      @(negedge clk);
      b1.log_rd_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      b1.memwrite = 0; b1.dataadr = 0; b1.writedata = 0; b1.log_rd_en = 0;
      b2.memwrite = 0; b2.dataadr = 0; b2.writedata = 0; b2.log_rd_en = 0;
      model_reset();

      // reset state, then a passing sequence
      #21 check_status("rst");
      #1 rst_n = 1;
      store(80, 5);
      store(80, 9);
      check_status("pre_pass");
      store(84, 7);
      check_status("pass");
      pop_chk("p0"); pop_chk("p1"); pop_chk("p2");
      chk("drained", b1.log_valid, 0);
      // pop when empty is ignored
      b1.log_rd_en = 1; @(negedge clk); b1.log_rd_en = 0;
      chk("empty_pop", b1.log_level, 0);

      // bad address fails, later stores ignored
      do_reset();
      store(60, 3);
      check_status("fail60");
      store(84, 7);
      check_status("ignored");

      // right address, wrong data
      do_reset();
      store(84, 6);
      check_status("fail84");

      // overflow: ten pushes with no pops
      do_reset();
      for (int k = 1; k <= 10; k++) store(80, k);
      check_status("ovf");
      chk("ovf.head", {b1.log_addr, b1.log_data}, {32'd80, 32'd1});
      for (int k = 0; k < 8; k++) pop_chk("ovf_drain");

      // pop concurrent with the 9th push into a full log
      do_reset();
      for (int k = 1; k <= 8; k++) store(80, k);
      store_pop(80, 9);
      check_status("full_pp");
      for (int k = 0; k < 8; k++) pop_chk("pp_drain");

      // reset mid-sequence
      do_reset();
      store(80, 1);
      store(80, 2);
      @(negedge clk); rst_n = 0;
      model_reset();
      #1 check_status("midrst");
      @(negedge clk); rst_n = 1;
      store(84, 7);
      check_status("after_rst");

      // timeout, no stores: asserted exactly 20 cycles after release
      @(negedge clk); rst2_n = 0;
      @(negedge clk); rst2_n = 1;
      chk("to.rst", b2.timeout, 0);
      repeat (19) @(negedge clk);
      chk("to.19", b2.timeout, 0);
      chk("to.19done", b2.done, 0);
      @(negedge clk);
      chk("to.20", b2.timeout, 1);
      chk("to.20done", b2.done, 1);
      chk("to.20pass", b2.pass, 0);

      // passing store on the final cycle beats the timeout
      @(negedge clk); rst2_n = 0;
      @(negedge clk); rst2_n = 1;
      repeat (19) @(negedge clk);
      b2.memwrite = 1; b2.dataadr = 84; b2.writedata = 7;
      @(negedge clk);
      b2.memwrite = 0;
      chk("race.pass", b2.pass, 1);
      chk("race.tmo", b2.timeout, 0);
      chk("race.cnt", b2.store_count, 1);
      @(negedge clk);
      chk("race.hold", b2.pass, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/store_result_checker.md
Name: store_result_checker

Overview:
- Synthesizable monitor downstream of the single-cycle MIPS top. It consumes the processor's data-memory store bus (memwrite, dataadr, writedata).
- Judges pass/fail/timeout in hardware, so the result can drive board LEDs as well as simulation.
- Logs every observed store into a small FWFT FIFO for host/bench readout.
- Counts stores and captures the first offending store.

Parameters:
PASS_ADDR, 84, store address that ends the test when paired with PASS_DATA
PASS_DATA, 7, store data that signals success at PASS_ADDR
ALLOW_ADDR, 80, the only other address a store may target without failing
TIMEOUT_CYCLES, 1000, cycles in RUN before declaring timeout (≥1)
LOG_DEPTH, 8, store-log FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset)
memwrite  in  1  store strobe from processor
dataadr  in  32  store address
writedata  in  32  store data
log_rd_en  in  1  pop head of store log
done  out  1  checker left RUN
pass  out  1  PASS state
fail  out  1  FAIL state
timeout  out  1  TIMEOUT state
store_count  out  16  stores observed in RUN, saturating
fail_addr  out  32  address of offending store
fail_data  out  32  data of offending store
log_valid  out  1  log non-empty
log_addr  out  32  head entry address (FWFT)
log_data  out  32  head entry data (FWFT)
log_level  out  clog2(LOG_DEPTH)+1  entries held
log_overflow  out  1  sticky: a store was dropped because log full

Behaviour:
- All state and outputs are registered.
- reset=0: asynchronously sets state=RUN, all outputs 0, FIFO empty, cycle counter 0. A reset mid-run aborts immediately and the checker restarts in RUN after release.
- States and encoding: RUN=00, PASS=01, FAIL=10, TIMEOUT=11. done = state!=RUN. pass/fail/timeout are one-hot decodes of the state.
- In RUN, on each rising edge with memwrite=1, the checker samples dataadr/writedata in the same cycle:
  - dataadr==PASS_ADDR and writedata==PASS_DATA → PASS.
  - else dataadr!=ALLOW_ADDR → FAIL; fail_addr/fail_data capture the store.
  - else (ALLOW_ADDR, any data) → remain RUN.
  - PASS_ADDR with the wrong data → FAIL.
- Every memwrite in RUN:
  - increments store_count, saturating at 0xFFFF.
  - pushes {dataadr, writedata} to the log, including the terminating store.
- Cycle counter increments each RUN cycle. When it reaches TIMEOUT_CYCLES-1 with no terminating store, the next state is TIMEOUT. A store arriving in that same cycle takes priority over the timeout.
- PASS/FAIL/TIMEOUT are terminal until reset:
  - memwrite ignored.
  - counters frozen; fail_* held.
  - log reads remain allowed.
- Outputs become visible one cycle after the deciding edge (latency 1).
- Log FIFO:
  - Head is presented combinationally from storage (FWFT). log_addr/log_data are valid only when log_valid=1.
  - log_rd_en with log_valid=1 pops; log_rd_en when empty is ignored.
  - Push when full with no pop: entry dropped, log_overflow set (sticky until reset).
  - Push and pop in the same cycle when full: both occur, level unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only (nothing to pop).
  - Read/write pointers wrap modulo LOG_DEPTH; log_level tracks 0..LOG_DEPTH.

Test Plan:
- Reset low 22 ns, then stores (80,5),(80,9),(84,7) → pass=1 and done=1 one cycle after the third store; store_count=3; log_level=3; pops return (80,5),(80,9),(84,7), then log_valid=0.
- Store (60,3) after reset → fail=1, fail_addr=60, fail_data=3; a subsequent store (84,7) is ignored and store_count stays 1.
- Store (84,6) → fail=1 with fail_addr=84, fail_data=6.
- TIMEOUT_CYCLES=20, no stores → timeout=1 exactly 20 cycles after reset release. Repeat with a (84,7) store on cycle 19 → pass=1, timeout=0.
- LOG_DEPTH=8, ten (80,k) stores for k=1..10 with no pops → log_level=8, log_overflow=1, head=(80,1). Repeat with a pop concurrent with the 9th push → no overflow, level 8.
- Assert reset low for one cycle mid-sequence after two stores → all outputs 0, log empty; a fresh (84,7) store → pass=1, store_count=1.
